// File: rtl/winograd_tile_scheduler.sv
// winograd_tile_scheduler: walks stride-OUT_TILE 4x4 tiles over a feature map through a PE with a tile-buffer/output handshake; ports: clk, reset (async active-low), start/abort/busy/done control, kernel_load, tile request handshake, pe_load, output handshake, tile_count
module winograd_tile_scheduler #(
  parameter int IMG_H      = 8,
  parameter int IMG_W      = 8,
  parameter int TILE       = 4,
  parameter int OUT_TILE   = 2,
  parameter int PE_LATENCY = 3,
  parameter int COORD_W    = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  output logic                   busy,
  output logic                   done,
  output logic                   kernel_load,
  output logic                   tile_req_valid,
  input  logic                   tile_req_ready,
  output logic [COORD_W-1:0]     tile_row,
  output logic [COORD_W-1:0]     tile_col,
  output logic                   pe_load,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [COORD_W-1:0]     out_row,
  output logic [COORD_W-1:0]     out_col,
  output logic [2*COORD_W-1:0]   tile_count
);
  localparam int CW = $clog2(PE_LATENCY + 1);
  localparam logic [COORD_W-1:0] ROW_LAST = COORD_W'(IMG_H - TILE);
  localparam logic [COORD_W-1:0] COL_LAST = COORD_W'(IMG_W - TILE);
  localparam logic [COORD_W-1:0] STEP     = COORD_W'(OUT_TILE);
  typedef enum logic [2:0] {IDLE, LOAD_KERNEL, REQ_TILE, PE_WAIT, WRITE_OUT, DONE} state_t;
  state_t state, state_next;
  logic [CW-1:0] wait_cnt;
  logic accept, last_tile;
  assign busy        = state != IDLE;
  assign done        = state == DONE;
  assign kernel_load = state == LOAD_KERNEL;
  // abort suppresses the handshakes so no tile is loaded or retired in the aborting cycle
  assign tile_req_valid = state == REQ_TILE && !abort;
  assign out_valid      = state == WRITE_OUT && !abort;
  assign pe_load        = tile_req_valid & tile_req_ready;
  assign accept         = out_valid & out_ready;
  assign out_row        = tile_row;
  assign out_col        = tile_col;
  assign last_tile      = tile_row == ROW_LAST && tile_col == COL_LAST;
  always_comb begin
    state_next = state;
    case (state)
      IDLE:        state_next = start ? LOAD_KERNEL : IDLE;
      LOAD_KERNEL: state_next = REQ_TILE;
      REQ_TILE:    state_next = tile_req_ready ? PE_WAIT : REQ_TILE;
      PE_WAIT:     state_next = wait_cnt == CW'(1) ? WRITE_OUT : PE_WAIT;
      WRITE_OUT:   state_next = out_ready ? (last_tile ? DONE : REQ_TILE) : WRITE_OUT;
      DONE:        state_next = IDLE;
      default:     state_next = IDLE;
    endcase
    if (abort && state != IDLE) state_next = IDLE;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      tile_row   <= '0;
      tile_col   <= '0;
      tile_count <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && start) begin
        tile_row   <= '0;
        tile_col   <= '0;
        tile_count <= '0;
      end
      if (pe_load) wait_cnt <= CW'(PE_LATENCY);
      else if (state == PE_WAIT && !abort) wait_cnt <= wait_cnt - CW'(1);
      if (accept) begin
        tile_count <= tile_count + (2*COORD_W)'(1);
        tile_col   <= tile_col < COL_LAST ? tile_col + STEP : '0;
        tile_row   <= tile_col < COL_LAST ? tile_row : tile_row + STEP;
      end
    end
  end
endmodule

// File: doc/winograd_tile_scheduler.md
Name: winograd_tile_scheduler

Overview:
- Sequences one Winograd F(2x2,3x3) processing element across an IMG_H x IMG_W single-plane feature map.
- Issues a kernel-load pulse, then walks 4x4 input tiles in raster order with stride 2. Each tile is requested from the tile buffer, loaded into the PE, held for the fixed PE latency, and its 2x2 result is handed to the output writer.
- Sits between the top-level layer controller (start/done) and the PE, tile buffer and output buffer.

Parameters:
- IMG_H, 8, feature-map rows; (IMG_H-TILE) must be divisible by OUT_TILE.
- IMG_W, 8, feature-map columns; same divisibility rule.
- TILE, 4, input tile edge.
- OUT_TILE, 2, output tile edge, which is also the tile stride.
- PE_LATENCY, 3, cycles from pe_load to valid PE output; must be at least 1.
- COORD_W, 8, width of row/column coordinates.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begin a layer pass; sampled only in IDLE.
- abort  in  1  cancel the pass; return to IDLE next cycle with no done.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last tile is written.
- kernel_load  out  1  one-cycle pulse telling the PE to latch Kernel.
- tile_req_valid  out  1  tile fetch request.
- tile_req_ready  in  1  tile buffer accepts the request.
- tile_row  out  COORD_W  top-left row of the current tile.
- tile_col  out  COORD_W  top-left column of the current tile.
- pe_load  out  1  equals tile_req_valid & tile_req_ready; the PE latches inpData this cycle.
- out_valid  out  1  a 2x2 result is available.
- out_ready  in  1  the writer accepts the result.
- out_row  out  COORD_W  output origin row; equals tile_row.
- out_col  out  COORD_W  output origin column; equals tile_col.
- tile_count  out  COORD_W*2  tiles completed in the current pass.

Behaviour:
- Reset (reset=0, asynchronous):
  - state goes to IDLE.
  - All outputs become 0, including counters and coordinates.
  - Reset takes effect immediately, mid-pass included; no done is produced.
- States: IDLE, LOAD_KERNEL, REQ_TILE, PE_WAIT, WRITE_OUT, DONE.
- IDLE:
  - On start=1, go to LOAD_KERNEL.
  - Clear tile_row, tile_col and tile_count.
- LOAD_KERNEL:
  - kernel_load=1 for exactly one cycle.
  - Go to REQ_TILE.
- REQ_TILE:
  - tile_req_valid=1.
  - tile_row and tile_col are stable until the handshake.
  - On the handshake cycle, pe_load=1; load the wait counter with PE_LATENCY and go to PE_WAIT.
- PE_WAIT:
  - Lasts exactly PE_LATENCY cycles.
  - Then go to WRITE_OUT.
- WRITE_OUT:
  - out_valid=1; out_row and out_col are held stable while out_ready=0.
  - On the accepting cycle, increment tile_count.
  - If tile_col < IMG_W-TILE: tile_col += OUT_TILE.
  - Otherwise tile_col = 0 and tile_row += OUT_TILE.
  - If this was the last tile (row = IMG_H-TILE and col = IMG_W-TILE), go to DONE; otherwise go to REQ_TILE.
- DONE:
  - done=1 for one cycle; busy is still 1.
  - Go to IDLE.
  - tile_count holds its final value until the next start.
- Tile count:
  - Tiles per pass = ((IMG_H-TILE)/OUT_TILE+1) * ((IMG_W-TILE)/OUT_TILE+1).
  - Defaults give 9 tiles.
- start while busy is ignored.
- abort in any non-IDLE state:
  - Go to IDLE on the next edge.
  - No done, no further handshakes.
  - abort has priority over a simultaneous handshake or accept, so tile_count does not increment.
- Minimum per-tile cost with ready held high is 1 + PE_LATENCY + 1 cycles.
- The scheduler never asserts tile_req_valid and out_valid in the same cycle.

Test Plan:
- Full pass, defaults, both readies tied 1, start pulsed at edge 0:
  - kernel_load at cycle 1.
  - Tile origins in order: (0,0),(0,2),(0,4),(2,0),(2,2),(2,4),(4,0),(4,2),(4,4).
  - Each pe_load is followed by out_valid exactly 4 cycles later.
  - done at cycle 47; tile_count=9; busy drops at cycle 48.
- Output backpressure: out_ready=0 for 4 cycles on tile 3.
  - out_valid stays high with out_row/out_col=(2,0) stable.
  - No new tile_req_valid appears; done is delayed by 4 cycles to cycle 51.
- Request backpressure: tile_req_ready=0 for 3 cycles on the first tile.
  - pe_load occurs only on the accepting cycle.
  - The PE_WAIT count starts from that cycle.
- Abort after tile 5 is accepted:
  - busy=0 on the next cycle; done never pulses.
  - tile_count frozen at 5; a later start restarts from (0,0) with count 0.
- Asynchronous reset asserted mid PE_WAIT, between clock edges:
  - All outputs read 0 before the next edge.
  - After release, the block waits in IDLE until start.
- start asserted while busy and again during DONE:
  - Both are ignored; exactly one pass and one done pulse.
